// File: rtl/morse_encoder.sv
// Debounces a Morse key, classifies presses as dot/dash, packs up to 5 symbols per letter into a 10-bit word.
// Latency: 2 sync + DEBOUNCE_CYCLES to a debounced edge; word_valid holds until word_ready accepts it.
module morse_encoder #(
  parameter int TICK_CYCLES      = 5_000_000,
  parameter int DASH_TICKS       = 3,
  parameter int LETTER_GAP_TICKS = 7,
  parameter int DEBOUNCE_CYCLES  = 250_000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       key_n,
  input  logic       commit_n,
  input  logic       word_ready,
  output logic       word_valid,
  output logic [9:0] word,
  output logic [2:0] symbol_count,
  output logic       symbol_pulse,
  output logic       busy
);

  localparam int TW  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int DW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DRW = $clog2(DASH_TICKS + 1);
  localparam int GW  = $clog2(LETTER_GAP_TICKS + 1);

  localparam logic [TW-1:0]  TICK_MAX = TW'(TICK_CYCLES - 1);
  localparam logic [DW-1:0]  DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DRW-1:0] DUR_MAX  = DRW'(DASH_TICKS);
  localparam logic [GW-1:0]  GAP_MAX  = GW'(LETTER_GAP_TICKS);

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP, S_HOLD} state_t;

  // bit 0 = key, bit 1 = commit; all levels idle high
  logic [1:0]    sync1, sync2, db, db_q;
  logic [DW-1:0] db_cnt [2];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '1;
      sync2 <= '1;
      db    <= '1;
      db_q  <= '1;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= {commit_n, key_n};
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic key_press, key_up, commit_edge;
  assign key_press   = db_q[0] & ~db[0];
  assign key_up      = db[0];
  assign commit_edge = db_q[1] & ~db[1];

  logic [TW-1:0] tick_cnt;
  logic          tick;
  assign tick = (tick_cnt == TICK_MAX);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)   tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  state_t         state, state_nx;
  logic [DRW-1:0] dur;
  logic [GW-1:0]  gap;
  logic [2:0]     count;
  logic [9:0]     shreg, shreg_app;
  logic [1:0]     sym;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Timeout and commit beat a same-cycle press; presses never act outside IDLE/GAP.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (key_press) state_nx = S_PRESS;
      S_PRESS: if (key_up) state_nx = (count == 3'd4) ? S_HOLD : S_GAP;
      S_GAP: begin
        if (gap == GAP_MAX || commit_edge) state_nx = S_HOLD;
        else if (key_press)                state_nx = S_PRESS;
      end
      S_HOLD:  if (word_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    sym       = (dur >= DUR_MAX) ? 2'b11 : 2'b01;
    shreg_app = shreg;
    for (int i = 0; i < 5; i++) begin
      if (count == 3'(i)) shreg_app[9-2*i -: 2] = sym;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dur          <= '0;
      gap          <= '0;
      count        <= '0;
      shreg        <= '0;
      symbol_pulse <= 1'b0;
    end else begin
      symbol_pulse <= 1'b0;
      case (state)
        S_IDLE: if (key_press) dur <= '0;
        S_PRESS: begin
          // a release wins over a same-cycle tick, so dur is classified as-is
          if (key_up) begin
            shreg        <= shreg_app;
            count        <= count + 1'b1;
            symbol_pulse <= 1'b1;
            gap          <= '0;
          end else if (tick && dur != DUR_MAX) begin
            dur <= dur + 1'b1;
          end
        end
        S_GAP: begin
          if (state_nx == S_PRESS)             dur <= '0;
          else if (tick && gap != GAP_MAX)     gap <= gap + 1'b1;
        end
        S_HOLD: begin
          if (word_ready) begin
            shreg <= '0;
            count <= '0;
            dur   <= '0;
            gap   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    word_valid   = (state == S_HOLD);
    word         = (state == S_HOLD) ? shreg : 10'd0;
    symbol_count = (state == S_HOLD) ? count : 3'd0;
    busy         = (state != S_IDLE);
  end

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench: letter-level model predicts packed words and symbol counts; a negedge monitor checks handshake and words.
module tb_morse_encoder;

  logic       clock = 1'b0;
  logic       resetn, key_n, commit_n, word_ready;
  logic       word_valid, symbol_pulse, busy;
  logic [9:0] word;
  logic [2:0] symbol_count;

  int checks = 0;
  int errors = 0;

  morse_encoder #(
    .TICK_CYCLES(4), .DASH_TICKS(3), .LETTER_GAP_TICKS(5), .DEBOUNCE_CYCLES(2)
  ) dut (
    .clock(clock), .resetn(resetn), .key_n(key_n), .commit_n(commit_n),
    .word_ready(word_ready), .word_valid(word_valid), .word(word),
    .symbol_count(symbol_count), .symbol_pulse(symbol_pulse), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: a press of >=16 cycles must be a dash, <=8 cycles a dot (tick = 4 cycles, dash = 3 ticks).
  logic [1:0]  cur_syms [$];
  logic [12:0] exp_q [$];
  int exp_pulses = 0;
  int exp_coinc  = 0;
  int exp_words  = 0;

  task automatic model_end();
    logic [9:0] w;
    w = '0;
    for (int i = 0; i < cur_syms.size(); i++) w = w | (10'(cur_syms[i]) << (8 - 2*i));
    if (cur_syms.size() > 0) begin
      exp_q.push_back({3'(cur_syms.size()), w});
      exp_words++;
    end
    cur_syms.delete();
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #3;
    end
  endtask

  task automatic key_sym(input int cycles);
    key_n = 1'b0;
    cyc(cycles);
    key_n = 1'b1;
    cur_syms.push_back((cycles >= 16) ? 2'b11 : 2'b01);
    exp_pulses++;
    if (cur_syms.size() == 5) begin
      exp_coinc++;
      model_end();
    end
  endtask

  // Monitor
  int         n_pulse = 0, n_coinc = 0, n_words = 0;
  logic       prev_vld = 0, prev_rdy = 0;
  logic [9:0] prev_word = 0, last_word = 0;
  logic [2:0] prev_cnt = 0, last_cnt = 0;
  logic [12:0] e;

  always @(negedge clock) begin
    if (resetn) begin
      if (!word_valid) check("count_when_invalid", 32'(symbol_count), 0);
      if (prev_vld && !prev_rdy) begin
        check("valid_dropped", 32'(word_valid), 1);
        check("word_stable", 32'(word), 32'(prev_word));
        check("count_stable", 32'(symbol_count), 32'(prev_cnt));
      end
      if (prev_vld && prev_rdy) check("valid_after_xfer", 32'(word_valid), 0);
      if (symbol_pulse) begin
        n_pulse++;
        if (word_valid && !prev_vld) begin
          n_coinc++;
          check("fifth_pulse_count", 32'(symbol_count), 5);
        end
      end
      if (word_valid && word_ready) begin
        n_words++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%0h expected=none", word);
        end else begin
          e = exp_q.pop_front();
          check("word", 32'(word), 32'(e[9:0]));
          check("symbol_count", 32'(symbol_count), 32'(e[12:10]));
        end
        last_word = word;
        last_cnt  = symbol_count;
      end
      prev_vld  = word_valid;
      prev_rdy  = word_ready;
      prev_word = word;
      prev_cnt  = symbol_count;
    end else begin
      prev_vld = 1'b0;
      prev_rdy = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int p0, k;

  initial begin
    resetn = 1'b0; key_n = 1'b1; commit_n = 1'b1; word_ready = 1'b1;
    cyc(2);
    check("rst_word_valid", 32'(word_valid), 0);
    check("rst_word", 32'(word), 0);
    check("rst_symbol_count", 32'(symbol_count), 0);
    check("rst_symbol_pulse", 32'(symbol_pulse), 0);
    check("rst_busy", 32'(busy), 0);
    resetn = 1'b1;
    cyc(5);

    // single dot
    p0 = n_pulse;
    key_sym(6);
    model_end();
    cyc(40);
    check("s1_pulses", 32'(n_pulse - p0), 1);
    check("s1_word_lit", 32'(last_word), 32'(10'b01_00_00_00_00));
    check("s1_count_lit", 32'(last_cnt), 1);
    check("s1_idle", 32'(busy), 0);

    // dot dash dot
    key_sym(6);  cyc(8);
    key_sym(20); cyc(8);
    key_sym(6);
    model_end();
    cyc(40);
    check("s2_word_lit", 32'(last_word), 32'(10'b01_11_01_00_00));
    check("s2_count_lit", 32'(last_cnt), 3);

    // five dashes, then a sixth press held across HOLD
    p0 = n_pulse;
    for (int i = 0; i < 4; i++) begin
      key_sym(20);
      cyc(8);
    end
    key_sym(20);
    word_ready = 1'b0;
    for (k = 0; k < 20 && !word_valid; k++) cyc(1);
    check("s3_hold_reached", 32'(word_valid), 1);
    key_n = 1'b0;
    cyc(10);
    word_ready = 1'b1;
    cyc(10);
    check("s3_busy_after_xfer", 32'(busy), 0);
    key_n = 1'b1;
    cyc(30);
    check("s3_no_sixth", 32'(n_pulse - p0), 5);
    check("s3_word_lit", 32'(last_word), 32'(10'b11_11_11_11_11));
    check("s3_count_lit", 32'(last_cnt), 5);
    check("s3_idle", 32'(busy), 0);

    // dot then early commit
    key_sym(6);
    model_end();
    cyc(4);
    commit_n = 1'b0;
    for (k = 0; k < 20 && !word_valid; k++) cyc(1);
    check("s4_commit_fast", 32'(k <= 8), 1);
    commit_n = 1'b1;
    cyc(20);
    check("s4_word_lit", 32'(last_word), 32'(10'b01_00_00_00_00));
    // commit while idle does nothing
    commit_n = 1'b0; cyc(6); commit_n = 1'b1;
    cyc(20);
    check("s4_idle_commit_busy", 32'(busy), 0);

    // consumer stalls for 50 cycles
    word_ready = 1'b0;
    key_sym(6);
    model_end();
    for (k = 0; k < 60 && !word_valid; k++) cyc(1);
    check("s5_hold_reached", 32'(word_valid), 1);
    cyc(50);
    check("s5_still_valid", 32'(word_valid), 1);
    check("s5_word_held", 32'(word), 32'(10'b01_00_00_00_00));
    check("s5_count_held", 32'(symbol_count), 1);
    word_ready = 1'b1;
    cyc(1);
    check("s5_busy_next", 32'(busy), 0);
    check("s5_valid_next", 32'(word_valid), 0);
    cyc(10);

    // bounce
    p0 = n_pulse;
    for (int i = 0; i < 10; i++) begin
      key_n = ~key_n;
      cyc(1);
    end
    key_n = 1'b1;
    cyc(30);
    check("s6_bounce_pulses", 32'(n_pulse - p0), 0);
    check("s6_bounce_busy", 32'(busy), 0);

    // reset in PRESS with two symbols stored
    key_sym(6); cyc(8);
    key_sym(6); cyc(8);
    key_n = 1'b0;
    cyc(8);
    check("s7_busy_before_rst", 32'(busy), 1);
    resetn = 1'b0;
    #1;
    check("s7_rst_valid", 32'(word_valid), 0);
    check("s7_rst_word", 32'(word), 0);
    check("s7_rst_count", 32'(symbol_count), 0);
    check("s7_rst_pulse", 32'(symbol_pulse), 0);
    check("s7_rst_busy", 32'(busy), 0);
    key_n = 1'b1;
    cur_syms.delete();
    cyc(3);
    resetn = 1'b1;
    cyc(40);
    check("s7_busy_after", 32'(busy), 0);

    check("total_pulses", 32'(n_pulse), 32'(exp_pulses));
    check("fifth_coincident", 32'(n_coinc), 32'(exp_coinc));
    check("total_words", 32'(n_words), 32'(exp_words));
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
